// File: rtl/rob_param_pkg.sv
// Shared types and sizing for the parametrised reorder buffer.
package rob_param_pkg;

    localparam int unsigned ROB_SIZE = 8;
    localparam int unsigned TAG_W    = $clog2(ROB_SIZE);
    localparam int unsigned CNT_W    = TAG_W + 1;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;

    typedef logic [TAG_W-1:0] rob_tag_t;
    typedef logic [XLEN-1:0]  xlen_t;

    // Common data bus broadcast from a completing functional unit.
    typedef struct packed {
        logic     valid;
        rob_tag_t rob_tag;
        xlen_t    value;
    } cdb_data_t;

    // One reorder-buffer slot.
    typedef struct packed {
        logic             valid;
        logic             wr_mem;
        logic [REG_W-1:0] dest_reg;
        xlen_t            value;
        xlen_t            dest_addr;
        rob_tag_t         store_dep;
        logic             value_ready;
        logic             address_ready;
    } rob_entry_t;

    localparam rob_entry_t EMPTY_ROB_ENTRY = '0;

    // Distance of a tag from the head; pointers wrap naturally in TAG_W bits.
    function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
        return tag - head;
    endfunction

endpackage

// File: rtl/rob_param_if.sv
// Dispatch / CDB / load-check / commit / flush bundle around the ROB.
interface rob_param_if;
    import rob_param_pkg::*;

    logic             alloc_valid;
    logic             alloc_ready;
    logic             alloc_wr_mem;
    logic [REG_W-1:0] alloc_dest_reg;
    xlen_t            alloc_value;
    logic             alloc_value_valid;
    rob_tag_t         alloc_store_dep;
    rob_tag_t         alloc_tag;
    cdb_data_t        cdb_data;
    rob_tag_t         read_tag;
    xlen_t            read_value;
    logic             read_ready;
    rob_tag_t         load_tag;
    xlen_t            load_address;
    logic             load_block;
    logic             load_fwd_valid;
    xlen_t            load_fwd_value;
    logic             head_valid;
    rob_entry_t       head_entry;
    logic             commit_ready;
    logic             flush_valid;
    rob_tag_t         flush_tag;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;

    modport master (
        output alloc_valid, alloc_wr_mem, alloc_dest_reg, alloc_value, alloc_value_valid,
               alloc_store_dep, cdb_data, read_tag, load_tag, load_address, commit_ready,
               flush_valid, flush_tag,
        input  alloc_ready, alloc_tag, read_value, read_ready, load_block, load_fwd_valid,
               load_fwd_value, head_valid, head_entry, count, empty, full
    );

    modport slave (
        input  alloc_valid, alloc_wr_mem, alloc_dest_reg, alloc_value, alloc_value_valid,
               alloc_store_dep, cdb_data, read_tag, load_tag, load_address, commit_ready,
               flush_valid, flush_tag,
        output alloc_ready, alloc_tag, read_value, read_ready, load_block, load_fwd_valid,
               load_fwd_value, head_valid, head_entry, count, empty, full
    );

endinterface

// File: rtl/rob_param_store_scan.sv
// Age-ordered store->load disambiguation: block on unknown older store addresses,
// otherwise forward from the youngest older store to the same address.
module rob_store_scan
    import rob_param_pkg::*;
(
    input  logic [ROB_SIZE-1:0] entry_valid,
    input  logic [ROB_SIZE-1:0] store_valid,
    input  logic [ROB_SIZE-1:0] addr_ready,
    input  logic [ROB_SIZE-1:0] data_ready,
    input  xlen_t               store_addr [ROB_SIZE],
    input  xlen_t               store_data [ROB_SIZE],
    input  rob_tag_t            head,
    input  rob_tag_t            load_tag,
    input  xlen_t               load_address,
    output logic                load_block,
    output logic                load_fwd_valid,
    output xlen_t               load_fwd_value
);

    rob_tag_t load_age;
    rob_tag_t idx;
    rob_tag_t hit_idx;
    logic     any_unknown;
    logic     hit;

    // Walk oldest to youngest so the last match seen is the youngest older store.
    always_comb begin
        load_block     = 1'b0;
        load_fwd_valid = 1'b0;
        load_fwd_value = '0;
        load_age       = rob_age(load_tag, head);
        idx            = '0;
        hit_idx        = '0;
        any_unknown    = 1'b0;
        hit            = 1'b0;
        for (int unsigned a = 0; a < ROB_SIZE; a++) begin
            idx = head + rob_tag_t'(a);
            if (rob_tag_t'(a) < load_age && store_valid[idx]) begin
                if (!addr_ready[idx]) begin
                    any_unknown = 1'b1;
                end else if (store_addr[idx] == load_address) begin
                    hit     = 1'b1;
                    hit_idx = idx;
                end
            end
        end
        if (entry_valid[load_tag]) begin
            if (any_unknown) begin
                load_block = 1'b1;
            end else if (hit) begin
                if (data_ready[hit_idx]) begin
                    load_fwd_valid = 1'b1;
                    load_fwd_value = store_data[hit_idx];
                end else begin
                    load_block = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order alloc/commit, out-of-order CDB completion,
// mispredict tail rollback and store->load forwarding.
module rob_param
    import rob_param_pkg::*;
(
    input logic        clock,
    input logic        reset,
    rob_param_if.slave bus
);

    rob_entry_t       rob_q [ROB_SIZE];
    rob_entry_t       rob_n [ROB_SIZE];
    rob_entry_t       new_entry;
    rob_tag_t         head_q, head_n, tail_q, tail_n, flush_age, cdb_tag;
    logic [CNT_W-1:0] count_q, count_n;
    logic             alloc_ready_int, alloc_fire, commit_fire, head_ok;
    logic             flush_hit, cdb_hit, dep_capture;

    logic [ROB_SIZE-1:0] ent_valid, st_valid, st_addr_ready, st_data_ready;
    xlen_t               st_addr [ROB_SIZE];
    xlen_t               st_data [ROB_SIZE];
    logic                scan_block, scan_fwd_valid;
    xlen_t               scan_fwd_value;

    // Handshake qualifiers; alloc never looks at same-cycle commit.
    always_comb begin
        cdb_tag         = bus.cdb_data.rob_tag;
        head_ok         = rob_q[head_q].valid && rob_q[head_q].value_ready
                          && rob_q[head_q].address_ready;
        alloc_ready_int = (count_q != CNT_W'(ROB_SIZE)) && !bus.flush_valid;
        alloc_fire      = bus.alloc_valid && alloc_ready_int;
        commit_fire     = head_ok && bus.commit_ready;
        flush_hit       = bus.flush_valid && rob_q[bus.flush_tag].valid;
        flush_age       = rob_age(bus.flush_tag, head_q);
        cdb_hit         = bus.cdb_data.valid && rob_q[cdb_tag].valid;
        dep_capture     = bus.alloc_wr_mem && !bus.alloc_value_valid && cdb_hit
                          && !rob_q[cdb_tag].wr_mem && (cdb_tag == bus.alloc_store_dep);
    end

    // Entry written at the tail on alloc.
    always_comb begin
        new_entry               = EMPTY_ROB_ENTRY;
        new_entry.valid         = 1'b1;
        new_entry.wr_mem        = bus.alloc_wr_mem;
        new_entry.dest_reg      = bus.alloc_dest_reg;
        new_entry.store_dep     = bus.alloc_store_dep;
        new_entry.address_ready = !bus.alloc_wr_mem;
        new_entry.value_ready   = bus.alloc_value_valid || dep_capture;
        if (dep_capture) begin
            new_entry.value = bus.cdb_data.value;
        end else if (bus.alloc_value_valid) begin
            new_entry.value = bus.alloc_value;
        end
    end

    // Next entry array: CDB, then alloc, commit clear, flush squash.
    always_comb begin
        rob_n = rob_q;
        if (cdb_hit) begin
            if (rob_q[cdb_tag].wr_mem) begin
                rob_n[cdb_tag].dest_addr     = bus.cdb_data.value;
                rob_n[cdb_tag].address_ready = 1'b1;
            end else begin
                rob_n[cdb_tag].value       = bus.cdb_data.value;
                rob_n[cdb_tag].value_ready = 1'b1;
                for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                    if (rob_q[i].valid && rob_q[i].wr_mem && !rob_q[i].value_ready
                        && rob_q[i].store_dep == cdb_tag) begin
                        rob_n[i].value       = bus.cdb_data.value;
                        rob_n[i].value_ready = 1'b1;
                    end
                end
            end
        end
        if (alloc_fire) begin
            rob_n[tail_q] = new_entry;
        end
        if (commit_fire) begin
            rob_n[head_q] = EMPTY_ROB_ENTRY;
        end
        if (flush_hit) begin
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                if (rob_age(rob_tag_t'(i), head_q) > flush_age) begin
                    rob_n[i] = EMPTY_ROB_ENTRY;
                end
            end
        end
    end

    // Pointer and occupancy update; flush rolls the tail back behind the branch.
    always_comb begin
        head_n = head_q + rob_tag_t'(commit_fire);
        if (flush_hit) begin
            tail_n  = bus.flush_tag + rob_tag_t'(1);
            count_n = CNT_W'(flush_age) + CNT_W'(1) - CNT_W'(commit_fire);
        end else begin
            tail_n  = tail_q + rob_tag_t'(alloc_fire);
            count_n = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                rob_q[i] <= EMPTY_ROB_ENTRY;
            end
        end else begin
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            for (int unsigned i = 0; i < ROB_SIZE; i++) begin
                rob_q[i] <= rob_n[i];
            end
        end
    end

    // Flatten store fields for the disambiguation scan.
    always_comb begin
        for (int unsigned i = 0; i < ROB_SIZE; i++) begin
            ent_valid[i]     = rob_q[i].valid;
            st_valid[i]      = rob_q[i].valid && rob_q[i].wr_mem;
            st_addr_ready[i] = rob_q[i].address_ready;
            st_data_ready[i] = rob_q[i].value_ready;
            st_addr[i]       = rob_q[i].dest_addr;
            st_data[i]       = rob_q[i].value;
        end
    end

    rob_store_scan u_scan (
        .entry_valid    (ent_valid),
        .store_valid    (st_valid),
        .addr_ready     (st_addr_ready),
        .data_ready     (st_data_ready),
        .store_addr     (st_addr),
        .store_data     (st_data),
        .head           (head_q),
        .load_tag       (bus.load_tag),
        .load_address   (bus.load_address),
        .load_block     (scan_block),
        .load_fwd_valid (scan_fwd_valid),
        .load_fwd_value (scan_fwd_value)
    );

    assign bus.alloc_ready    = alloc_ready_int;
    assign bus.alloc_tag      = tail_q;
    assign bus.read_value     = rob_q[bus.read_tag].value;
    assign bus.read_ready     = rob_q[bus.read_tag].valid && rob_q[bus.read_tag].value_ready;
    assign bus.load_block     = scan_block;
    assign bus.load_fwd_valid = scan_fwd_valid;
    assign bus.load_fwd_value = scan_fwd_value;
    assign bus.head_valid     = head_ok;
    assign bus.head_entry     = rob_q[head_q];
    assign bus.count          = count_q;
    assign bus.empty          = (count_q == '0);
    assign bus.full           = (count_q == CNT_W'(ROB_SIZE));

endmodule

// File: tb/tb_rob_param.sv
// Randomized scoreboard bench for rob_param against a queue-based program-order model.
module tb_rob_param;
    import rob_param_pkg::*;

    localparam int RS = int'(ROB_SIZE);

    logic clock;
    logic reset;

    rob_param_if bus ();

    rob_param dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: in-flight instructions in program order; element 0 is the oldest.
    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] addr;
        int          dep;
        logic        vr;
        logic        ar;
    } m_ent_t;

    typedef struct {
        logic        alloc_ready;
        int          alloc_tag;
        logic [31:0] read_value;
        logic        read_ready;
        logic        load_block;
        logic        fwd_valid;
        logic [31:0] fwd_value;
        logic        head_valid;
        int          count;
        logic        empty;
        logic        full;
    } exp_cyc_t;

    m_ent_t   mq[$];
    int       mhead;
    exp_cyc_t cyc_q[$];
    m_ent_t   com_q[$];
    int       n_vec = 0;
    int       n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pos(input int t);
        return (t - mhead + RS) % RS;
    endfunction

    function automatic void drive_idle();
        bus.alloc_valid       = 1'b0;
        bus.alloc_wr_mem      = 1'b0;
        bus.alloc_dest_reg    = '0;
        bus.alloc_value       = '0;
        bus.alloc_value_valid = 1'b0;
        bus.alloc_store_dep   = '0;
        bus.cdb_data          = '0;
        bus.read_tag          = '0;
        bus.load_tag          = '0;
        bus.load_address      = '0;
        bus.commit_ready      = 1'b0;
        bus.flush_valid       = 1'b0;
        bus.flush_tag         = '0;
    endfunction

    // Expected combinational outputs for the inputs now on the bus.
    function automatic void push_expect();
        exp_cyc_t e;
        int sz;
        int p;
        int lp;
        bit unk;
        sz = mq.size();
        e = '{default: '0};
        e.alloc_ready = (sz != RS) && !bus.flush_valid;
        e.alloc_tag   = (mhead + sz) % RS;
        p = pos(int'(bus.read_tag));
        if (p < sz) begin
            e.read_value = mq[p].val;
            e.read_ready = mq[p].vr;
        end
        lp = pos(int'(bus.load_tag));
        if (lp < sz) begin
            unk = 0;
            for (int k = 0; k < lp; k++) begin
                if (mq[k].wr && !mq[k].ar) unk = 1;
            end
            if (unk) begin
                e.load_block = 1'b1;
            end else begin
                for (int k = lp - 1; k >= 0; k--) begin
                    if (mq[k].wr && mq[k].addr == bus.load_address) begin
                        if (mq[k].vr) begin
                            e.fwd_valid = 1'b1;
                            e.fwd_value = mq[k].val;
                        end else begin
                            e.load_block = 1'b1;
                        end
                        break;
                    end
                end
            end
        end
        e.head_valid = (sz > 0) && mq[0].vr && mq[0].ar;
        e.count      = sz;
        e.empty      = (sz == 0);
        e.full       = (sz == RS);
        cyc_q.push_back(e);
    endfunction

    // Advance the model by one clock edge given the current inputs.
    function automatic void model_step();
        int sz;
        int pf;
        int ct;
        bit commit;
        bit flush;
        bit alloc;
        bit cap;
        m_ent_t ne;
        sz     = mq.size();
        commit = (sz > 0) && mq[0].vr && mq[0].ar && bus.commit_ready;
        pf     = pos(int'(bus.flush_tag));
        flush  = bus.flush_valid && (pf < sz);
        alloc  = bus.alloc_valid && (sz != RS) && !bus.flush_valid;
        if (commit) com_q.push_back(mq[0]);
        cap = 0;
        if (bus.cdb_data.valid) begin
            ct = pos(int'(bus.cdb_data.rob_tag));
            if (ct < sz) begin
                if (mq[ct].wr) begin
                    mq[ct].addr = bus.cdb_data.value;
                    mq[ct].ar   = 1'b1;
                end else begin
                    cap = bus.alloc_wr_mem && !bus.alloc_value_valid
                          && (int'(bus.alloc_store_dep) == int'(bus.cdb_data.rob_tag));
                    mq[ct].val = bus.cdb_data.value;
                    mq[ct].vr  = 1'b1;
                    for (int k = 0; k < sz; k++) begin
                        if (mq[k].wr && !mq[k].vr && mq[k].dep == int'(bus.cdb_data.rob_tag)) begin
                            mq[k].val = bus.cdb_data.value;
                            mq[k].vr  = 1'b1;
                        end
                    end
                end
            end
        end
        if (alloc) begin
            ne.wr   = bus.alloc_wr_mem;
            ne.rd   = bus.alloc_dest_reg;
            ne.dep  = int'(bus.alloc_store_dep);
            ne.addr = '0;
            ne.ar   = !bus.alloc_wr_mem;
            ne.vr   = bus.alloc_value_valid || cap;
            ne.val  = cap ? bus.cdb_data.value : (bus.alloc_value_valid ? bus.alloc_value : 32'h0);
        end
        if (flush) begin
            while (mq.size() > pf + 1) void'(mq.pop_back());
        end
        if (commit) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % RS;
        end
        if (alloc) mq.push_back(ne);
    endfunction

    function automatic void gen_inputs(input int cyc);
        int sz;
        int k;
        int a_pct;
        int c_pct;
        int f_pct;
        sz = mq.size();
        if (cyc >= 1400 && cyc < 1500) begin
            a_pct = 90; c_pct = 0; f_pct = 0;
        end else if ((cyc / 250) % 2 == 0) begin
            a_pct = 75; c_pct = 30; f_pct = 4;
        end else begin
            a_pct = 40; c_pct = 85; f_pct = 4;
        end
        bus.alloc_valid       = 1'($urandom_range(99) < a_pct);
        bus.alloc_wr_mem      = 1'($urandom_range(99) < 40);
        bus.alloc_dest_reg    = 5'($urandom);
        bus.alloc_value       = 32'($urandom);
        bus.alloc_store_dep   = rob_tag_t'($urandom);
        bus.alloc_value_valid = 1'($urandom_range(99) < 20);
        if (bus.alloc_wr_mem) begin
            if (sz > 0) begin
                k = int'($urandom_range(sz - 1));
                bus.alloc_store_dep = rob_tag_t'((mhead + k) % RS);
                if (mq[k].wr || mq[k].vr) bus.alloc_value_valid = 1'b1;
                else bus.alloc_value_valid = 1'($urandom_range(1));
            end else begin
                bus.alloc_value_valid = 1'b1;
            end
        end
        bus.cdb_data.valid = 1'($urandom_range(99) < 60);
        if (sz > 0 && $urandom_range(9) != 0) begin
            k = int'($urandom_range(sz - 1));
            bus.cdb_data.rob_tag = rob_tag_t'((mhead + k) % RS);
            if (mq[k].wr) bus.cdb_data.value = 32'h100 + 32'(4 * $urandom_range(3));
            else bus.cdb_data.value = 32'($urandom);
        end else begin
            bus.cdb_data.rob_tag = rob_tag_t'($urandom);
            bus.cdb_data.value   = 32'($urandom);
        end
        bus.read_tag     = rob_tag_t'($urandom);
        bus.load_tag     = rob_tag_t'($urandom);
        bus.load_address = 32'h100 + 32'(4 * $urandom_range(3));
        bus.commit_ready = 1'($urandom_range(99) < c_pct);
        bus.flush_valid  = 1'($urandom_range(99) < f_pct);
        bus.flush_tag    = rob_tag_t'($urandom);
    endfunction

    // Monitor: compare every sampled cycle and every observed commit.
    always @(negedge clock) begin : monitor
        exp_cyc_t e;
        m_ent_t   c;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("alloc_ready",    32'(bus.alloc_ready),    32'(e.alloc_ready));
            chk("alloc_tag",      32'(bus.alloc_tag),      32'(e.alloc_tag));
            chk("read_value",     32'(bus.read_value),     e.read_value);
            chk("read_ready",     32'(bus.read_ready),     32'(e.read_ready));
            chk("load_block",     32'(bus.load_block),     32'(e.load_block));
            chk("load_fwd_valid", 32'(bus.load_fwd_valid), 32'(e.fwd_valid));
            chk("load_fwd_value", 32'(bus.load_fwd_value), e.fwd_value);
            chk("head_valid",     32'(bus.head_valid),     32'(e.head_valid));
            chk("count",          32'(bus.count),          32'(e.count));
            chk("empty",          32'(bus.empty),          32'(e.empty));
            chk("full",           32'(bus.full),           32'(e.full));
            if (bus.head_valid && bus.commit_ready) begin
                if (com_q.size() == 0) begin
                    chk("commit_unexpected", 32'(bus.head_valid), 32'h0);
                end else begin
                    c = com_q.pop_front();
                    chk("commit_wr_mem",    32'(bus.head_entry.wr_mem),   32'(c.wr));
                    chk("commit_dest_reg",  32'(bus.head_entry.dest_reg), 32'(c.rd));
                    chk("commit_value",     32'(bus.head_entry.value),    c.val);
                    chk("commit_dest_addr", 32'(bus.head_entry.dest_addr), c.addr);
                end
            end
        end
    end

    // Driver: reset, random traffic with a fill-to-full phase, mid-stream reset.
    initial begin
        reset = 1'b1;
        drive_idle();
        mhead = 0;
        @(posedge clock);
        #1;
        push_expect();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                reset = 1'b1;
                drive_idle();
                mq.delete();
                mhead = 0;
                push_expect();
                @(posedge clock);
                #1;
                reset = 1'b0;
            end
            gen_inputs(cyc);
            push_expect();
            model_step();
            @(posedge clock);
            #1;
        end
        drive_idle();
        @(negedge clock);
        @(negedge clock);
        chk("commit_queue_drained", 32'(com_q.size()), 32'h0);
        chk("cycle_queue_drained",  32'(cyc_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
